// File: rtl/bus_transfer_ctrl.sv
// Bus transfer sequencer: drives one source register onto the shared bus, then strobes
// one destination register. Optional macro XFER_COUNT_EN adds an 8-bit completed-transfer counter.
module bus_transfer_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] src_sel,
  input  logic [1:0] dst_sel,
  input  logic [3:0] bus_in,
  output logic [3:0] src_en,
  output logic [3:0] dst_wr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] last_data
`ifdef XFER_COUNT_EN
  ,
  output logic [7:0] xfer_count
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, WRITE, HOLD} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [1:0] dst_q;
  logic [3:0] settle_cnt;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // NOTE: every register here is assigned with <= so that all state updates on an edge
  // see the pre-edge values; blocking assignments would make the outcome order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dst_q      <= '0;
      settle_cnt <= '0;
      src_en     <= '0;
      dst_wr     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      last_data  <= '0;
`ifdef XFER_COUNT_EN
      xfer_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (src_sel != dst_sel) begin
              // src_en itself holds the latched source for the whole transfer
              src_en     <= onehot(src_sel);
              dst_q      <= dst_sel;
              settle_cnt <= SETTLE_INIT;
              busy       <= 1'b1;
              state      <= SETTLE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            dst_wr <= onehot(dst_q);
            state  <= WRITE;
          end
        end
        WRITE: begin
          last_data <= bus_in;
          dst_wr    <= '0;
          state     <= HOLD;
        end
        HOLD: begin
          // Source stays enabled through HOLD so the destination latch closes on stable data
          src_en <= '0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
`ifdef XFER_COUNT_EN
          xfer_count <= xfer_count + 8'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
